light_sequencer: RTL

Controller that sequences the dynamic LED colour block (`light`). It generates the single-cycle `button` advance strobe and the `on_off` enable from an operator enable, an auto/manual mode select and a raw pushbutton. In auto mode it advances the colour every `dwell` clock cycles, and a manual press overrides the timer. It sits between the board I/O and `light`, whose `button`/`on_off` inputs it drives directly.

---
 rtl/light_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/light_sequencer.sv
// light_sequencer: drives the `light` block's button strobe and on_off enable.
// Raw pushbutton -> 2-flop synchroniser -> (optional debounce) -> rising-edge
// detect -> press. The OFF/MANUAL/AUTO FSM issues steps from presses and from a
// dwell down-counter in AUTO.
// Build option: define LIGHT_SEQ_DEBOUNCE_EN to compile in the debounce stage.
module light_sequencer #(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          auto_mode,
  input  logic          btn_raw,
  input  logic [DW-1:0] dwell,
  output logic          button,
  output logic          on_off,
  output logic [1:0]    state,
  output logic [7:0]    step_cnt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_MANUAL = 2'b01,
    ST_AUTO   = 2'b10
  } state_e;

  logic sync1_q, sync2_q;
  logic qual_lvl;
  logic clean_lvl;
  logic prev_q;
  logic press;

  // Two-flop synchroniser for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Level is accepted only when both synchroniser stages agree, so a button
  // level seen for a single sample never reaches the edge detector.
  assign qual_lvl = sync1_q & sync2_q;

`ifdef LIGHT_SEQ_DEBOUNCE_EN
  localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic           db_q, db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  // Debounced level follows the qualified level after DEBOUNCE stable cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (qual_lvl != db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE - 1)) begin
        db_d = qual_lvl;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign clean_lvl = db_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE == 0);
  assign clean_lvl       = qual_lvl;
`endif

  // Previous clean level for rising-edge detection; runs in every state so a
  // press held across OFF is not replayed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= clean_lvl;
    end
  end

  assign press = clean_lvl & ~prev_q;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          button_q, step_d;
  logic          on_off_q, on_off_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic          expire;

  // Next state, step decision, dwell counter and step count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    on_off_d   = 1'b0;

    if (!enable) begin
      state_d = ST_OFF;
    end else if (auto_mode) begin
      state_d = ST_AUTO;
    end else begin
      state_d = ST_MANUAL;
    end

    expire = (state_q == ST_AUTO) && (cnt_q == DW'(1));
    // A step due in a cycle that heads to OFF is dropped; press and expiry
    // together still give a single step.
    step_d = (state_q != ST_OFF) && (state_d != ST_OFF) && (press || expire);

    if (state_d == ST_OFF) begin
      cnt_d = '0;
    end else if ((state_d == ST_AUTO) && ((state_q != ST_AUTO) || step_d)) begin
      cnt_d = dwell;
    end else if ((state_q == ST_AUTO) && (state_d == ST_AUTO) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (state_d == ST_OFF) begin
      step_cnt_d = '0;
    end else if (step_d) begin
      step_cnt_d = step_cnt_q + 8'd1;
    end

    on_off_d = (state_d != ST_OFF);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      button_q   <= 1'b0;
      on_off_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      button_q   <= step_d;
      on_off_q   <= on_off_d;
    end
  end

  assign button   = button_q;
  assign on_off   = on_off_q;
  assign state    = state_q;
  assign step_cnt = step_cnt_q;

endmodule
